// File: rtl/mem_stage_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_bridge
// Purpose : MEM-stage posted write buffer with load forwarding and a
//           single-outstanding external memory bus.
// Rev     : 1.0  initial release
// ============================================================================
module mem_stage_bridge #(
    parameter int WB_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] alu_out_i32,
    input  logic [31:0] write_data_i32,
    input  logic        enable_wmem_i,
    input  logic        mem_to_reg_i,
    output logic [31:0] read_data_o32,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o32,
    output logic [31:0] bus_wdata_o32,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i32
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(WB_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [WB_DEPTH-1:0] r_valid;
    logic [29:0]      r_addr [WB_DEPTH];
    logic [31:0]      r_data [WB_DEPTH];

    logic        r_busy;
    logic        r_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_hold;

    logic        w_store;
    logic        w_load;
    logic        w_full;
    logic        w_push;
    logic        w_ack;
    logic        w_pop;
    logic        w_issue_wr;
    logic        w_issue_rd;
    logic        w_hit;
    logic [31:0] w_fwd;
    logic        w_stall;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Word addressing: the byte offset never takes part in matching or bus addresses.
    assign w_unused = ^alu_out_i32[1:0];

    // A simultaneous store and load request is handled as a store.
    assign w_store    = enable_wmem_i;
    assign w_load     = mem_to_reg_i & ~enable_wmem_i;
    assign w_full     = (r_count == C_FULL);
    assign w_push     = w_store && (r_state == S_IDLE) && !w_full;
    assign w_ack      = bus_ack_i && r_busy;
    assign w_pop      = w_ack && r_we;
    assign w_issue_wr = ((r_state == S_IDLE) || (r_state == S_DRAIN)) &&
                        (r_count != '0) && !r_busy;
    assign w_issue_rd = (r_state == S_READ) && !r_busy;

    // Walk oldest to youngest so the last match is the youngest store.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (r_valid[r_head + PTR_W'(k)] &&
                (r_addr[r_head + PTR_W'(k)] == alu_out_i32[31:2])) begin
                w_hit = 1'b1;
                w_fwd = r_data[r_head + PTR_W'(k)];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_rdata      = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_store) begin
                    w_stall = w_full;
                end else if (w_load) begin
                    if (w_hit) begin
                        w_rdata = w_fwd;
                    end else begin
                        w_stall      = 1'b1;
                        w_next_state = (r_count != '0) ? S_DRAIN : S_READ;
                    end
                end
            end
            S_DRAIN: begin
                w_stall = 1'b1;
                if ((r_count == '0) && !r_busy) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                w_stall = 1'b1;
                if (w_ack && !r_we) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Entry payload carries no reset; r_valid alone defines occupancy.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr[r_tail] <= alu_out_i32[31:2];
            r_data[r_tail] <= write_data_i32;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Bus outputs are registered and only reloaded while no transaction is open.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_busy      <= 1'b0;
            r_we        <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_hold      <= '0;
        end else begin
            if (w_ack) begin
                r_busy <= 1'b0;
                r_we   <= 1'b0;
                if (!r_we) begin
                    r_hold <= bus_rdata_i32;
                end
            end else if (w_issue_wr) begin
                r_busy      <= 1'b1;
                r_we        <= 1'b1;
                r_bus_addr  <= {r_addr[r_head], 2'b00};
                r_bus_wdata <= r_data[r_head];
            end else if (w_issue_rd) begin
                r_busy     <= 1'b1;
                r_we       <= 1'b0;
                r_bus_addr <= {alu_out_i32[31:2], 2'b00};
            end
        end
    end

    assign stall_o       = w_stall && reset_ni;
    assign read_data_o32 = w_rdata;
    assign bus_req_o     = r_busy;
    assign bus_we_o      = r_we;
    assign bus_addr_o32  = r_bus_addr;
    assign bus_wdata_o32 = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_bridge
// Purpose : Directed self-checking bench for mem_stage_bridge with a queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_stage_bridge;

    localparam int DEPTH = 4;
    localparam int BIG   = 1 << 30;

    logic        clk_i;
    logic        reset_ni;
    logic [31:0] alu_out_i32;
    logic [31:0] write_data_i32;
    logic        enable_wmem_i;
    logic        mem_to_reg_i;
    logic [31:0] read_data_o32;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o32;
    logic [31:0] bus_wdata_o32;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i32;

    mem_stage_bridge #(.WB_DEPTH(DEPTH)) u_dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .alu_out_i32    (alu_out_i32),
        .write_data_i32 (write_data_i32),
        .enable_wmem_i  (enable_wmem_i),
        .mem_to_reg_i   (mem_to_reg_i),
        .read_data_o32  (read_data_o32),
        .stall_o        (stall_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o32   (bus_addr_o32),
        .bus_wdata_o32  (bus_wdata_o32),
        .bus_ack_i      (bus_ack_i),
        .bus_rdata_i32  (bus_rdata_i32)
    );

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_hold;

    int n_vec;
    int n_fail;
    int n_wr;
    int n_rd;
    int acks_given;
    int ack_limit;
    int lat;
    int stray_req;
    int stray_seen;
    int stall_cycles;
    bit cmp_en;
    bit resp_is_write;
    bit resp_is_read;
    logic [31:0] rd_value;
    logic [31:0] exp_rd_addr;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: the buffer is a queue of stores awaiting a write ack; hold tracks the last read.
    initial begin
        m_hold = '0;
        forever begin
            @(posedge clk_i);
            if (!reset_ni) begin
                mq.delete();
                m_hold = '0;
            end else begin
                bit do_push;
                do_push = enable_wmem_i && (mq.size() < DEPTH);
                if (bus_ack_i && resp_is_write && (mq.size() > 0)) void'(mq.pop_front());
                if (bus_ack_i && resp_is_read) m_hold = rd_value;
                if (do_push) mq.push_back({alu_out_i32[31:2], write_data_i32});
            end
        end
    end

    // Compare process: pipeline-visible outputs against the model every cycle.
    initial begin
        stall_cycles = 0;
        forever begin
            bit          hit;
            logic [31:0] fwd;
            @(negedge clk_i);
            if (reset_ni && stall_o) stall_cycles++;
            if (cmp_en && reset_ni) begin
                if (enable_wmem_i) begin
                    chk("store_stall", 32'(stall_o), 32'(mq.size() == DEPTH));
                    chk("store_rdata", read_data_o32, m_hold);
                end else if (mem_to_reg_i) begin
                    hit = 1'b0;
                    fwd = '0;
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].a == alu_out_i32[31:2]) begin
                            hit = 1'b1;
                            fwd = mq[i].d;
                        end
                    end
                    if (hit) begin
                        chk("fwd_stall", 32'(stall_o), 32'd0);
                        chk("fwd_rdata", read_data_o32, fwd);
                    end
                end else begin
                    chk("idle_stall", 32'(stall_o), 32'd0);
                    chk("idle_rdata", read_data_o32, m_hold);
                end
            end
        end
    end

    // Memory responder: acks after lat request cycles, bounded by ack_limit.
    initial begin
        bit          active;
        int          cnt;
        logic [31:0] cap_addr;
        logic [31:0] cap_wd;
        logic        cap_we;
        bus_ack_i     = 1'b0;
        bus_rdata_i32 = 32'hDEAD_BEEF;
        resp_is_write = 1'b0;
        resp_is_read  = 1'b0;
        active        = 1'b0;
        cnt           = 0;
        cap_addr      = '0;
        cap_wd        = '0;
        cap_we        = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            bus_ack_i     = 1'b0;
            resp_is_write = 1'b0;
            resp_is_read  = 1'b0;
            bus_rdata_i32 = 32'hDEAD_BEEF;
            if (stray_req != stray_seen) begin
                stray_seen++;
                bus_ack_i = 1'b1;
                active    = 1'b0;
            end else if (!reset_ni || !bus_req_o) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    active   = 1'b1;
                    cnt      = 0;
                    cap_addr = bus_addr_o32;
                    cap_we   = bus_we_o;
                    cap_wd   = bus_wdata_o32;
                end else begin
                    chk("bus_addr_stable", bus_addr_o32, cap_addr);
                    chk("bus_we_stable", 32'(bus_we_o), 32'(cap_we));
                    if (cap_we) chk("bus_wdata_stable", bus_wdata_o32, cap_wd);
                end
                cnt++;
                if ((cnt >= lat) && (acks_given < ack_limit)) begin
                    acks_given++;
                    bus_ack_i = 1'b1;
                    active    = 1'b0;
                    if (cap_we) begin
                        resp_is_write = 1'b1;
                        n_wr++;
                        if (mq.size() == 0) begin
                            chk("wr_unexpected", bus_addr_o32, 32'hFFFF_FFFF);
                        end else begin
                            chk("wr_addr", bus_addr_o32, {mq[0].a, 2'b00});
                            chk("wr_data", bus_wdata_o32, mq[0].d);
                        end
                    end else begin
                        resp_is_read  = 1'b1;
                        n_rd++;
                        bus_rdata_i32 = rd_value;
                        chk("rd_addr", bus_addr_o32, exp_rd_addr);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        enable_wmem_i  = 1'b0;
        mem_to_reg_i   = 1'b0;
        alu_out_i32    = '0;
        write_data_i32 = '0;
    endtask

    // Called at posedge+1; holds the store until the bridge accepts it.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic ld);
        int g;
        alu_out_i32    = addr;
        write_data_i32 = data;
        enable_wmem_i  = 1'b1;
        mem_to_reg_i   = ld;
        @(negedge clk_i);
        g = 0;
        while (stall_o && (g < 100)) begin
            @(negedge clk_i);
            g++;
        end
        if (g >= 100) chk("store_accept_timeout", 32'(g), 32'd0);
        tick();
    endtask

    task automatic drain();
        int g;
        set_idle();
        ack_limit = BIG;
        g = 0;
        while (((mq.size() != 0) || bus_req_o) && (g < 300)) begin
            tick();
            g++;
        end
        chk("drain_timeout", 32'(g >= 300), 32'd0);
        repeat (3) tick();
        chk("drain_bus_quiet", 32'(bus_req_o), 32'd0);
    endtask

    initial begin
        int w0;
        int r0;
        int s0;
        int g;
        n_vec = 0; n_fail = 0; n_wr = 0; n_rd = 0;
        acks_given = 0; ack_limit = BIG; lat = 1;
        stray_req = 0; stray_seen = 0; cmp_en = 1'b0;
        rd_value = '0; exp_rd_addr = '0;
        set_idle();
        reset_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_req", 32'(bus_req_o), 32'd0);
        chk("reset_we", 32'(bus_we_o), 32'd0);
        chk("reset_rdata", read_data_o32, 32'd0);
        reset_ni = 1'b1;
        tick();
        cmp_en = 1'b1;

        // Posted stores with slow acks never stall.
        lat = 3; w0 = n_wr; s0 = stall_cycles;
        for (int i = 0; i < 4; i++) do_store(32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0);
        drain();
        chk("posted_writes", 32'(n_wr - w0), 32'd4);
        chk("posted_no_stall", 32'(stall_cycles - s0), 32'd0);

        // Full buffer: fifth store stalls until one ack frees a slot.
        lat = 1; w0 = n_wr; ack_limit = acks_given;
        for (int i = 0; i < 4; i++) do_store(32'h20 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b0);
        alu_out_i32 = 32'h30; write_data_i32 = 32'h2000_0004; enable_wmem_i = 1'b1;
        @(negedge clk_i);
        chk("full_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        chk("full_stall_held", 32'(stall_o), 32'd1);
        ack_limit = acks_given + 1;
        g = 0;
        while (stall_o && (g < 20)) begin
            @(negedge clk_i);
            g++;
        end
        chk("full_release", 32'(stall_o), 32'd0);
        tick();
        drain();
        chk("full_writes", 32'(n_wr - w0), 32'd5);

        // Forwarding with the head write parked on the bus.
        ack_limit = acks_given;
        do_store(32'h40, 32'h0000_AAAA, 1'b0);
        do_store(32'h50, 32'h0000_5555, 1'b0);
        do_store(32'h40, 32'h0000_BBBB, 1'b0);
        enable_wmem_i = 1'b0; mem_to_reg_i = 1'b1; alu_out_i32 = 32'h42;
        @(negedge clk_i);
        chk("fwd_lit_data", read_data_o32, 32'h0000_BBBB);
        chk("fwd_lit_stall", 32'(stall_o), 32'd0);
        tick();
        alu_out_i32 = 32'h53;
        @(negedge clk_i);
        chk("fwd_lit_data2", read_data_o32, 32'h0000_5555);
        tick();
        drain();

        // Miss load behind two buffered stores.
        ack_limit = acks_given;
        do_store(32'h100, 32'h0000_0001, 1'b0);
        do_store(32'h104, 32'h0000_0002, 1'b0);
        cmp_en = 1'b0; lat = 2; rd_value = 32'h1234_5678; exp_rd_addr = 32'h80;
        w0 = n_wr; r0 = n_rd;
        enable_wmem_i = 1'b0; mem_to_reg_i = 1'b1; alu_out_i32 = 32'h80;
        ack_limit = BIG;
        @(negedge clk_i);
        chk("miss_stall", 32'(stall_o), 32'd1);
        g = 0;
        while (stall_o && (g < 100)) begin
            @(negedge clk_i);
            g++;
        end
        chk("miss_timeout", 32'(g >= 100), 32'd0);
        chk("miss_done_data", read_data_o32, 32'h1234_5678);
        chk("miss_writes", 32'(n_wr - w0), 32'd2);
        chk("miss_reads", 32'(n_rd - r0), 32'd1);
        tick();
        set_idle();
        cmp_en = 1'b1;
        repeat (2) tick();

        // Reset while a read is outstanding, then a stray ack.
        cmp_en = 1'b0; lat = 20; exp_rd_addr = 32'h200;
        mem_to_reg_i = 1'b1; alu_out_i32 = 32'h200;
        g = 0;
        @(negedge clk_i);
        while (!bus_req_o && (g < 20)) begin
            @(negedge clk_i);
            g++;
        end
        chk("rst_req_seen", 32'(bus_req_o), 32'd1);
        #2;
        reset_ni = 1'b0;
        set_idle();
        #1;
        chk("rst_req_drop", 32'(bus_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_rdata", read_data_o32, 32'd0);
        tick();
        reset_ni = 1'b1;
        stray_req++;
        repeat (3) begin
            tick();
            chk("stray_req", 32'(bus_req_o), 32'd0);
            chk("stray_stall", 32'(stall_o), 32'd0);
        end
        cmp_en = 1'b1;

        // Ten stores wrap the pointers; one carries an illegal load flag too.
        lat = 1; w0 = n_wr;
        for (int i = 0; i < 10; i++)
            do_store(32'h300 + 32'(4 * i), 32'h5A5A_0000 + 32'(i) * 32'h0001_1111, (i == 5));
        drain();
        chk("wrap_writes", 32'(n_wr - w0), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
